// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
// Holds the digit and blank segment codes (bit0 = segment a .. bit6 = segment g,
// active-high), the monitor state enum and the "no digit" marker. The seg7
// encoder and the seg7_monitor both draw their codes from here.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Decade successor: 9 wraps to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_monitor_if.sv
// seg7_monitor_if: segment bus plus the monitor's result outputs.
//   ena, segments_in        : driven by the source side (master)
//   digit .. period_valid   : driven by the monitor (slave)
// PERIOD_W must match the PERIOD_W of the monitor attached to it.
interface seg7_monitor_if #(
  parameter int PERIOD_W = 24
);
  logic                ena;
  logic [6:0]          segments_in;
  logic [3:0]          digit;
  logic                digit_valid;
  logic                change_pulse;
  logic                seq_error;
  logic                bad_pattern;
  logic [7:0]          err_count;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;

  modport master (
    output ena, segments_in,
    input  digit, digit_valid, change_pulse, seq_error, bad_pattern,
           err_count, period, period_valid
  );

  modport slave (
    input  ena, segments_in,
    output digit, digit_valid, change_pulse, seq_error, bad_pattern,
           err_count, period, period_valid
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational segment pattern -> digit decoder.
//   pattern  : 7-bit segment code (bit0 = a)
//   digit    : decoded 0..9, or DIGIT_NONE for blank/invalid
//   is_digit : pattern is one of the ten digit codes
//   is_blank : pattern is all segments off
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    digit    = DIGIT_NONE;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_monitor.sv
// seg7_monitor: recovers the digit shown on a 7-segment bus, filters glitches,
// checks the 0..9 counting order, counts errors and measures change period.
//   clk, rst_n : clock, async active-low reset
//   bus.ena, bus.segments_in                 : inputs
//   bus.digit .. bus.period_valid            : registered results
//
// state | meaning
// IDLE  | no reference digit held (after reset, blank or invalid pattern)
// TRACK | a digit is held; next accepted digit is sequence-checked and timed
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input logic           clk,
  input logic           rst_n,
  seg7_monitor_if.slave bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0]          sync1_q, sync2_q;
  logic [6:0]          samp_q, samp_n;
  logic [3:0]          cnt_q, cnt_n, cnt_step;
  logic [6:0]          acc_q, acc_n;
  state_t              state_q, state_n;
  logic [3:0]          digit_q, digit_n;
  logic                valid_q, valid_n;
  logic                chg_q, chg_n;
  logic                seq_q, seq_n;
  logic                bad_q, bad_n;
  logic [7:0]          err_q, err_n;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_n, pcnt_inc;
  logic [PERIOD_W-1:0] period_q, period_n;
  logic                pv_q, pv_n;

  logic [3:0]          dec_digit;
  logic                dec_is_digit, dec_is_blank;

  // The synchronizer free-runs so filtering resumes on fresh data after ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.segments_in;
      sync2_q <= sync1_q;
    end
  end

  seg7_decode u_decode (
    .pattern  (sync2_q),
    .digit    (dec_digit),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  assign cnt_step = (sync2_q != samp_q) ? 4'd1 :
                    (cnt_q == STABLE)   ? cnt_q : cnt_q + 4'd1;
  assign pcnt_inc = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_W'(1);

  always_comb begin
    samp_n   = samp_q;
    cnt_n    = cnt_q;
    acc_n    = acc_q;
    state_n  = state_q;
    digit_n  = digit_q;
    valid_n  = valid_q;
    chg_n    = 1'b0;
    seq_n    = 1'b0;
    bad_n    = 1'b0;
    err_n    = err_q;
    pcnt_n   = pcnt_q;
    period_n = period_q;
    pv_n     = pv_q;

    if (bus.ena) begin
      samp_n = sync2_q;
      cnt_n  = cnt_step;
      if (state_q == TRACK) pcnt_n = pcnt_inc;

      // Comparing against the last accepted pattern makes acceptance one-shot
      // and keeps a steady blank bus silent after reset.
      if (cnt_step == STABLE && sync2_q != acc_q) begin
        acc_n = sync2_q;
        if (dec_is_digit) begin
          chg_n   = 1'b1;
          digit_n = dec_digit;
          valid_n = 1'b1;
          state_n = TRACK;
          pcnt_n  = '0;
          if (state_q == TRACK) begin
            seq_n    = (dec_digit != next_digit(digit_q));
            // The acceptance cycle itself counts toward the interval.
            period_n = pcnt_inc;
            pv_n     = 1'b1;
          end
        end else begin
          digit_n = DIGIT_NONE;
          valid_n = 1'b0;
          state_n = IDLE;
          bad_n   = !dec_is_blank;
        end
        if ((seq_n || bad_n) && err_q != 8'hFF) err_n = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= SEG_BLANK;
      state_q  <= IDLE;
      digit_q  <= DIGIT_NONE;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      seq_q    <= 1'b0;
      bad_q    <= 1'b0;
      err_q    <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      samp_q   <= samp_n;
      cnt_q    <= cnt_n;
      acc_q    <= acc_n;
      state_q  <= state_n;
      digit_q  <= digit_n;
      valid_q  <= valid_n;
      chg_q    <= chg_n;
      seq_q    <= seq_n;
      bad_q    <= bad_n;
      err_q    <= err_n;
      pcnt_q   <= pcnt_n;
      period_q <= period_n;
      pv_q     <= pv_n;
    end
  end

  assign bus.digit        = digit_q;
  assign bus.digit_valid  = valid_q;
  assign bus.change_pulse = chg_q;
  assign bus.seq_error    = seq_q;
  assign bus.bad_pattern  = bad_q;
  assign bus.err_count    = err_q;
  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Observes a 7-segment output bus, such as the digit display driven by the team's decade counter and `seg7` decoder, and recovers the displayed digit. It filters glitches, checks that successive digits follow the 0→9→0 counting sequence, counts violations and measures the number of clock cycles between digit changes. It sits on the display side as a self-check and loopback block, and its results are exposed on outputs for the bench or for a debug mux.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical synchronized samples required before a pattern is accepted; legal range 1..15.
- `PERIOD_W`, default 24: width of the period counter and the period output.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: when low, every register except the synchronizer holds its value.
- `segments_in` input 7: segment bus, active-high; bit0 is segment a through bit6, which is segment g.
- `digit` output 4: last accepted digit; 4'hF when none is held.
- `digit_valid` output 1: high while `digit` holds a decoded 0..9.
- `change_pulse` output 1: one-cycle strobe on the acceptance of a new digit.
- `seq_error` output 1: one-cycle strobe when an accepted digit is not the successor of the previous one.
- `bad_pattern` output 1: one-cycle strobe when an accepted pattern is neither a digit nor blank.
- `err_count` output 8: saturating count of `seq_error` plus `bad_pattern` events.
- `period` output `PERIOD_W`: enabled cycles between the last two accepted digit changes.
- `period_valid` output 1: `period` holds a real measurement.

## Operation
- **Decode table:** 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; blank=7'h00. Every other code is invalid.
- **Synchronizer:** 2-flop synchronizer on `segments_in`; it runs regardless of `ena`.
- **Stability filter:**
  - A 4-bit counter resets to 1 whenever the synchronized sample differs from the previous synchronized sample.
  - Otherwise it increments and saturates at `STABLE_CYCLES`.
  - A pattern is accepted on the cycle the counter reaches `STABLE_CYCLES` and differs from the last accepted pattern.
  - A pattern is accepted once only; it is not re-accepted while it is held.
- **State machine** (IDLE, TRACK):
  - **IDLE:** no reference digit is held. Accepting a digit loads `digit`, sets `digit_valid`, pulses `change_pulse`, performs no sequence check, clears the period counter and moves to TRACK.
  - **TRACK, digit d accepted:** pulses `change_pulse` and loads `digit`.
    - Expected successor is (prev==9 ? 0 : prev+1); a mismatch pulses `seq_error`.
    - `period` is loaded from the period counter, `period_valid` is set and the counter is cleared.
  - **Blank accepted (either state):** `digit`=F, `digit_valid`=0, no error, next state IDLE. `period_valid` keeps its value.
  - **Invalid pattern accepted (either state):** pulses `bad_pattern`, then behaves as blank.
- **Period counter:** increments on every enabled cycle in TRACK and saturates at all-ones. A saturated value is reported as-is.
- **Error counter:** `err_count` increments by 1 per error event and saturates at 255. `seq_error` and `bad_pattern` cannot coincide.

## Timing
- **Reset values:** `digit`=F, `digit_valid`=0, `change_pulse`=0, `seq_error`=0, `bad_pattern`=0, `err_count`=0, `period`=0, `period_valid`=0, state IDLE. The last-accepted pattern register resets to 7'h00 (blank), so a blank bus produces no event after reset. Synchronizer and filter counter reset to 0.
- **Latency:** a clean change on `segments_in` is reflected on the outputs `STABLE_CYCLES`+2 rising edges later.
- **Output registering:** all outputs are registered; strobes are high for exactly one cycle.
- **Period measurement:** for an input changing every N cycles with `ena`=1, `period`=N.
- **Glitches:** a glitch shorter than `STABLE_CYCLES` synchronized cycles produces no event and does not disturb the held digit.
- **`ena` low:** freezes the filter counter, state, counters and outputs; strobes are forced low. Filtering resumes on the synchronizer's current value.
- **Reset mid-operation:** `rst_n` asserted at any time returns every output to its reset value immediately; no pulse is emitted on release.

## Structure
- **Shared package `seg7_pkg`:** holds the ten digit codes and the blank code, the state enum (IDLE, TRACK) and the invalid-digit constant 4'hF. The existing `seg7` encoder draws its codes from the same package.
- **Sub-module `seg7_decode`:** combinational pattern→{digit, is_digit, is_blank}; it holds the only copy of the decode table in the monitor.
- **Counters and filter:** stability filter, FSM, period counter and error counter live in `seg7_monitor`.

## Test plan
- **Clean sequence:** after reset with `STABLE_CYCLES`=4, drive 3F,06,5B,…,6F,3F, each held 100 cycles → 11 `change_pulse`, `seq_error` never set, `period`=100 with `period_valid`=1 after the 2nd change, `err_count`=0.
- **Skip:** drive 06 then 4F (1→3) → `seq_error` pulse on acceptance of 3, `err_count`=1, `digit`=3.
- **Glitch:** hold 66, drive 7F for 3 cycles, then 66 → no `change_pulse`, `digit` stays 4. Repeat with 7F held for 4 cycles → `change_pulse`, then `seq_error`.
- **Invalid and blank:** drive 7'h55 → `bad_pattern` and `digit`=F. Then drive 00 → no event. Then drive 5B → `change_pulse`, no `seq_error`.
- **Saturation:** force 300 alternating 1/3 errors → `err_count`=255. `PERIOD_W`=4 with changes every 40 cycles → `period`=15.
- **Reset and enable:** assert `rst_n` low mid-count → all outputs at reset values on the same cycle. Drop `ena` for 50 cycles during a 100-cycle digit → measured `period`=50.
